hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 34 +++
 rtl/hazard_scoreboard_match.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard_pkg
//  Purpose  : Shared constants, default stage indices and parameter defaults
//             for the pipeline hazard scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Forwarding select value meaning "read the register file".
    localparam int FWD_NONE = 0;

    // Default stage numbering of the tracked post-decode pipeline.
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    // Parameter defaults for the classic five-stage pipeline.
    localparam int DEF_NSTAGE   = STG_WB;
    localparam int DEF_AW       = 5;
    localparam int DEF_RDY_ALU  = STG_MEM;
    localparam int DEF_RDY_LD   = STG_WB;
    localparam int DEF_BR_STAGE = STG_WB;

    // A producer found in stage k reaches stage k+1 by the time the consumer
    // sits in EX; if that is still earlier than the stage where its result
    // becomes forwardable, the consumer has to wait in decode.
    function automatic logic tooEarly(input int stage, input logic isLoad,
                                      input int rdyAlu, input int rdyLd);
        return (stage + 1) < (isLoad ? rdyLd : rdyAlu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_match.sv
`default_nettype none
// ============================================================================
//  Module   : hz_match
//  Purpose  : Youngest-producer priority finder. Searches the tracked stages
//             for the smallest stage index that holds a valid register writer
//             whose destination equals the source. Register 0 never matches.
//  Revision : 1.0  initial release
// ============================================================================
module hz_match #(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int FW     = 2
) (
    input  logic [AW-1:0]             i_src,
    input  logic                      i_srcUsed,
    input  logic [NSTAGE:1]           i_stgValid,
    input  logic [NSTAGE:1]           i_stgWr,
    input  logic [NSTAGE:1]           i_stgIsLoad,
    input  logic [NSTAGE:1][AW-1:0]   i_stgDst,
    output logic                      o_hit,
    output logic [FW-1:0]             o_stage,
    output logic                      o_isLoad
);

    // Scan oldest to youngest so the last hit written is the youngest writer;
    // non-writing entries never take part, so they cannot shadow an older one.
    always_comb begin
        o_hit    = 1'b0;
        o_stage  = '0;
        o_isLoad = 1'b0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (i_srcUsed && (i_src != '0) && i_stgValid[k] && i_stgWr[k] &&
                (i_stgDst[k] == i_src)) begin
                o_hit    = 1'b1;
                o_stage  = FW'(k);
                o_isLoad = i_stgIsLoad[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Tracks the instructions in the post-decode stages, stalls
//             decode on load-use style hazards, selects forwarding sources
//             for the EX operands and flushes younger work on a redirect.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE   = DEF_NSTAGE,
    parameter int AW       = DEF_AW,
    parameter int RDY_ALU  = DEF_RDY_ALU,
    parameter int RDY_LD   = DEF_RDY_LD,
    parameter int BR_STAGE = DEF_BR_STAGE
) (
    input  logic                          clock,
    input  logic                          start,
    input  logic                          id_valid,
    input  logic [AW-1:0]                 id_rs,
    input  logic [AW-1:0]                 id_rt,
    input  logic                          id_rs_used,
    input  logic                          id_rt_used,
    input  logic                          id_wr,
    input  logic [AW-1:0]                 id_dst,
    input  logic                          id_is_load,
    input  logic                          br_redirect,
    output logic                          id_stall,
    output logic                          id_kill,
    output logic [$clog2(NSTAGE+1)-1:0]   fwd_a,
    output logic [$clog2(NSTAGE+1)-1:0]   fwd_b,
    output logic [NSTAGE-1:0]             stage_valid,
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   flush_cnt
);

    localparam int          FW        = $clog2(NSTAGE + 1);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Per-stage entry fields; index k is pipeline stage k (1 = EX).
    logic [NSTAGE:1]          r_valid;
    logic [NSTAGE:1]          r_wr;
    logic [NSTAGE:1]          r_isLoad;
    logic [NSTAGE:1]          r_rsUsed;
    logic [NSTAGE:1]          r_rtUsed;
    logic [NSTAGE:1][AW-1:0]  r_dst;
    logic [NSTAGE:1][AW-1:0]  r_rs;
    logic [NSTAGE:1][AW-1:0]  r_rt;
    logic [15:0]              r_stallCnt;
    logic [15:0]              r_flushCnt;

    logic                     w_decHitA, w_decHitB;
    logic                     w_decLoadA, w_decLoadB;
    logic [FW-1:0]            w_decStageA, w_decStageB;
    logic                     w_fwdHitA, w_fwdHitB;
    logic                     w_fwdLoadA, w_fwdLoadB;
    logic [FW-1:0]            w_fwdStageA, w_fwdStageB;
    logic [NSTAGE:1]          w_olderValid;
    logic                     w_needStall;
    logic                     w_unused;

    // Decode-side searches cover every tracked stage.
    hz_match #(.NSTAGE(NSTAGE), .AW(AW), .FW(FW)) u_matchDecRs (
        .i_src       (id_rs),
        .i_srcUsed   (id_rs_used),
        .i_stgValid  (r_valid),
        .i_stgWr     (r_wr),
        .i_stgIsLoad (r_isLoad),
        .i_stgDst    (r_dst),
        .o_hit       (w_decHitA),
        .o_stage     (w_decStageA),
        .o_isLoad    (w_decLoadA)
    );

    hz_match #(.NSTAGE(NSTAGE), .AW(AW), .FW(FW)) u_matchDecRt (
        .i_src       (id_rt),
        .i_srcUsed   (id_rt_used),
        .i_stgValid  (r_valid),
        .i_stgWr     (r_wr),
        .i_stgIsLoad (r_isLoad),
        .i_stgDst    (r_dst),
        .o_hit       (w_decHitB),
        .o_stage     (w_decStageB),
        .o_isLoad    (w_decLoadB)
    );

    // EX-operand searches only look at older stages 2..NSTAGE, so stage 1 is
    // masked out of the valid vector.
    assign w_olderValid = {r_valid[NSTAGE:2], 1'b0};

    hz_match #(.NSTAGE(NSTAGE), .AW(AW), .FW(FW)) u_matchExRs (
        .i_src       (r_rs[1]),
        .i_srcUsed   (r_rsUsed[1] & r_valid[1]),
        .i_stgValid  (w_olderValid),
        .i_stgWr     (r_wr),
        .i_stgIsLoad (r_isLoad),
        .i_stgDst    (r_dst),
        .o_hit       (w_fwdHitA),
        .o_stage     (w_fwdStageA),
        .o_isLoad    (w_fwdLoadA)
    );

    hz_match #(.NSTAGE(NSTAGE), .AW(AW), .FW(FW)) u_matchExRt (
        .i_src       (r_rt[1]),
        .i_srcUsed   (r_rtUsed[1] & r_valid[1]),
        .i_stgValid  (w_olderValid),
        .i_stgWr     (r_wr),
        .i_stgIsLoad (r_isLoad),
        .i_stgDst    (r_dst),
        .o_hit       (w_fwdHitB),
        .o_stage     (w_fwdStageB),
        .o_isLoad    (w_fwdLoadB)
    );

    // A redirect wins over a stall: the decode instruction is being killed.
    assign w_needStall = (w_decHitA && tooEarly(int'(w_decStageA), w_decLoadA, RDY_ALU, RDY_LD)) ||
                         (w_decHitB && tooEarly(int'(w_decStageB), w_decLoadB, RDY_ALU, RDY_LD));
    assign id_stall    = id_valid & ~br_redirect & w_needStall;
    assign id_kill     = br_redirect;

    assign fwd_a       = w_fwdHitA ? w_fwdStageA : FW'(FWD_NONE);
    assign fwd_b       = w_fwdHitB ? w_fwdStageB : FW'(FWD_NONE);
    assign stage_valid = r_valid;
    assign stall_cnt   = r_stallCnt;
    assign flush_cnt   = r_flushCnt;

    // Retiring-stage source fields and the load flag of forwarding hits
    // carry no further meaning here.
    assign w_unused = &{1'b0, w_fwdLoadA, w_fwdLoadB, r_rs[NSTAGE], r_rt[NSTAGE],
                        r_rsUsed[NSTAGE], r_rtUsed[NSTAGE]};

    // Valid bits and event counters: reset clears everything at once, a
    // redirect invalidates the wrong-path entries moving into 1..BR_STAGE.
    always_ff @(posedge clock) begin
        if (start) begin
            r_valid    <= '0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_valid[1] <= id_valid & ~id_stall & ~br_redirect;
            for (int k = 2; k <= NSTAGE; k++) begin
                r_valid[k] <= r_valid[k-1] & ~(br_redirect & (k <= BR_STAGE));
            end
            if (id_stall && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
            if (br_redirect && (r_flushCnt != c_CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + 16'd1;
            end
        end
    end

    // Entry payload shifts every cycle; it is only meaningful where valid.
    always_ff @(posedge clock) begin
        r_wr[1]     <= id_wr;
        r_dst[1]    <= id_dst;
        r_isLoad[1] <= id_is_load;
        r_rs[1]     <= id_rs;
        r_rt[1]     <= id_rt;
        r_rsUsed[1] <= id_rs_used;
        r_rtUsed[1] <= id_rt_used;
        for (int k = 2; k <= NSTAGE; k++) begin
            r_wr[k]     <= r_wr[k-1];
            r_dst[k]    <= r_dst[k-1];
            r_isLoad[k] <= r_isLoad[k-1];
            r_rs[k]     <= r_rs[k-1];
            r_rt[k]     <= r_rt[k-1];
            r_rsUsed[k] <= r_rsUsed[k-1];
            r_rtUsed[k] <= r_rtUsed[k-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Directed self-checking bench for hazard_scoreboard, with a
//             default-parameter instance and a deep-pipeline instance
//             (NSTAGE=5, RDY_LD=5) sharing the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clock;
    logic        start;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_wr;
    logic [4:0]  id_dst;
    logic        id_is_load;
    logic        br_redirect;

    logic        id_stall,  id_kill;
    logic [1:0]  fwd_a,     fwd_b;
    logic [2:0]  stage_valid;
    logic [15:0] stall_cnt, flush_cnt;

    logic        id_stall5, id_kill5;
    logic [2:0]  fwd_a5,    fwd_b5;
    logic [4:0]  stage_valid5;
    logic [15:0] stall_cnt5, flush_cnt5;

    int nPass  = 0;
    int nFail  = 0;
    int nTotal = 0;

    hazard_scoreboard dut (
        .clock       (clock),
        .start       (start),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_wr       (id_wr),
        .id_dst      (id_dst),
        .id_is_load  (id_is_load),
        .br_redirect (br_redirect),
        .id_stall    (id_stall),
        .id_kill     (id_kill),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stage_valid (stage_valid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    hazard_scoreboard #(.NSTAGE(5), .RDY_LD(5)) dut5 (
        .clock       (clock),
        .start       (start),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_wr       (id_wr),
        .id_dst      (id_dst),
        .id_is_load  (id_is_load),
        .br_redirect (br_redirect),
        .id_stall    (id_stall5),
        .id_kill     (id_kill5),
        .fwd_a       (fwd_a5),
        .fwd_b       (fwd_b5),
        .stage_valid (stage_valid5),
        .stall_cnt   (stall_cnt5),
        .flush_cnt   (flush_cnt5)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setId(input logic v, input logic [4:0] rs, input logic rsU,
                         input logic [4:0] rt, input logic rtU, input logic wr,
                         input logic [4:0] dst, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsU;
        id_rt      = rt;
        id_rt_used = rtU;
        id_wr      = wr;
        id_dst     = dst;
        id_is_load = ld;
    endtask

    task automatic idle();
        setId(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset, with a redirect presented that must be ignored by the state.
        start       = 1'b1;
        br_redirect = 1'b1;
        idle();
        #2;
        chk("kill_follows_redirect", 32'(id_kill), 32'd1);
        tick();
        start       = 1'b0;
        br_redirect = 1'b0;
        #2;
        chk("rst_stage_valid", 32'(stage_valid), 32'd0);
        chk("rst_stall",       32'(id_stall),    32'd0);
        chk("rst_kill",        32'(id_kill),     32'd0);
        chk("rst_fwd_a",       32'(fwd_a),       32'd0);
        chk("rst_fwd_b",       32'(fwd_b),       32'd0);
        chk("rst_stall_cnt",   32'(stall_cnt),   32'd0);
        chk("rst_flush_cnt",   32'(flush_cnt),   32'd0);

        // lw $2 then add $3,$2,$4: one stall, then forward from WB.
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
        #2;
        chk("lw_no_stall", 32'(id_stall), 32'd0);
        tick();
        setId(1'b0, 5'd2, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0);
        #2;
        chk("dep_invalid_no_stall", 32'(id_stall), 32'd0);
        id_valid = 1'b1;
        #1;
        chk("loaduse_stall", 32'(id_stall), 32'd1);
        tick();
        #2;
        chk("loaduse_release",   32'(id_stall),    32'd0);
        chk("loaduse_stall_cnt", 32'(stall_cnt),   32'd1);
        chk("loaduse_bubble",    32'(stage_valid), 32'b010);
        tick();
        idle();
        #2;
        chk("loaduse_fwd_a",  32'(fwd_a),       32'd3);
        chk("loaduse_fwd_b",  32'(fwd_b),       32'd0);
        chk("loaduse_valid",  32'(stage_valid), 32'b101);
        drain(3);

        // add $2; sub $5,$2,$2: no stall, both operands from MEM.
        setId(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b0);
        tick();
        setId(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);
        #2;
        chk("alu_no_stall", 32'(id_stall), 32'd0);
        tick();
        idle();
        #2;
        chk("alu_fwd_a", 32'(fwd_a), 32'd2);
        chk("alu_fwd_b", 32'(fwd_b), 32'd2);
        drain(3);

        // Two writers of $2: the younger one is selected.
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
        tick();
        setId(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
        tick();
        setId(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
        #2;
        chk("young_no_stall", 32'(id_stall), 32'd0);
        tick();
        idle();
        #2;
        chk("young_fwd_a", 32'(fwd_a), 32'd2);
        drain(3);

        // A younger non-writer with dst $2 must not hide the older writer.
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0);
        tick();
        setId(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b0);
        tick();
        setId(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
        tick();
        idle();
        #2;
        chk("shadow_fwd_a", 32'(fwd_a), 32'd3);
        drain(3);

        // Redirect with all stages full and a load-use pending in decode.
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0);
        tick();
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0);
        tick();
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
        tick();
        setId(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        br_redirect = 1'b1;
        #2;
        chk("redir_kill",  32'(id_kill),  32'd1);
        chk("redir_stall", 32'(id_stall), 32'd0);
        tick();
        br_redirect = 1'b0;
        idle();
        #2;
        chk("redir_valid",     32'(stage_valid), 32'b000);
        chk("redir_flush_cnt", 32'(flush_cnt),   32'd1);
        chk("redir_stall_cnt", 32'(stall_cnt),   32'd1);
        drain(3);

        // $0 never matches, even against a load writing $0.
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);
        tick();
        setId(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0);
        #2;
        chk("r0_no_stall", 32'(id_stall), 32'd0);
        tick();
        idle();
        #2;
        chk("r0_fwd_a", 32'(fwd_a), 32'd0);
        chk("r0_fwd_b", 32'(fwd_b), 32'd0);
        drain(3);

        // Reset mid-operation drops every in-flight entry and the counters.
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0);
        tick();
        tick();
        tick();
        #2;
        chk("full_valid", 32'(stage_valid), 32'b111);
        start = 1'b1;
        tick();
        start = 1'b0;
        idle();
        #2;
        chk("midrst_valid",     32'(stage_valid), 32'd0);
        chk("midrst_stall_cnt", 32'(stall_cnt),   32'd0);
        chk("midrst_flush_cnt", 32'(flush_cnt),   32'd0);

        // Stall counter saturates at all-ones.
        force dut.r_stallCnt = 16'hFFFF;
        #1;
        release dut.r_stallCnt;
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
        tick();
        setId(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        #2;
        chk("sat_stall", 32'(id_stall), 32'd1);
        tick();
        #2;
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        drain(3);

        // Deep pipeline: load then dependent stalls three cycles.
        start = 1'b1;
        tick();
        start = 1'b0;
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
        tick();
        setId(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        #2;
        chk("deep_stall_1", 32'(id_stall5), 32'd1);
        tick();
        #2;
        chk("deep_stall_2", 32'(id_stall5), 32'd1);
        tick();
        #2;
        chk("deep_stall_3", 32'(id_stall5), 32'd1);
        tick();
        #2;
        chk("deep_release",   32'(id_stall5),  32'd0);
        chk("deep_stall_cnt", 32'(stall_cnt5), 32'd3);
        tick();
        idle();
        #2;
        chk("deep_fwd_a", 32'(fwd_a5), 32'd5);
        drain(5);

        // Deep pipeline redirect: the branch in stage 3 survives into stage 4.
        setId(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0);
        tick();
        tick();
        tick();
        idle();
        #2;
        chk("deep_pre_redir_valid", 32'(stage_valid5), 32'b00111);
        br_redirect = 1'b1;
        #1;
        chk("deep_redir_kill", 32'(id_kill5), 32'd1);
        tick();
        br_redirect = 1'b0;
        #2;
        chk("deep_redir_valid", 32'(stage_valid5), 32'b01000);
        chk("deep_flush_cnt",   32'(flush_cnt5),   32'd1);
        drain(2);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire
